sram_like_responder: RTL

Responder (slave) end of the core's SRAM-like memory interface: req/wr/size/wstrb/addr/wdata in, addr_ok/data_ok/rdata out. Accepts up to DEPTH outstanding requests, performs each against an internal word-addressed memory, and returns one response per accepted request, in order, no earlier than LATENCY cycles after acceptance. Sits behind the fetch or memory stage in simulation and FPGA test harnesses as the instruction or data memory model.

---
 rtl/sram_like_responder_pkg.sv | 30 +++
 rtl/sram_like_responder_resp_fifo.sv | 63 ++++++
 rtl/sram_like_responder.sv | 104 ++++++++++
 3 files changed

// File: rtl/sram_like_responder_pkg.sv
// Shared constants and helpers for the SRAM-like responder: transfer sizes,
// LFSR seed/taps for the optional RANDOM_DELAY_EN timing jitter, byte merging.
package sram_like_responder_pkg;

   localparam logic [1:0] SRAM_SIZE_BYTE = 2'b00;
   localparam logic [1:0] SRAM_SIZE_HALF = 2'b01;
   localparam logic [1:0] SRAM_SIZE_WORD = 2'b10;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] state);
      logic [7:0] shifted;
      shifted = state >> 1;
      return state[0] ? (shifted ^ LFSR_TAPS) : shifted;
   endfunction

   function automatic logic [31:0] sram_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/sram_like_responder_resp_fifo.sv
// resp_fifo: synchronous in-order response FIFO holding read data for accepted
// requests; pushes are dropped when full, pops are ignored when empty.
module sram_like_responder_resp_fifo
   import sram_like_responder_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;

   logic             w_do_push;
   logic             w_do_pop;
   logic [PTR_W-1:0] w_wptr_next;
   logic [PTR_W-1:0] w_rptr_next;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rptr];

   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   assign w_wptr_next = (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
   assign w_rptr_next = (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= w_wptr_next;
         if (w_do_pop)  r_rptr <= w_rptr_next;
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like memory responder: word-addressed memory, in-order responses after at
// least LATENCY cycles. Define RANDOM_DELAY_EN for LFSR-driven accept/response jitter.
module sram_like_responder
   import sram_like_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned LATENCY    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sram_req,
   input  logic        sram_wr,
   input  logic [1:0]  sram_size,
   input  logic [3:0]  sram_wstrb,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   output logic        sram_addr_ok,
   output logic        sram_data_ok,
   output logic [31:0] sram_rdata
);

   localparam int unsigned WORDS = 2 ** ADDR_WIDTH;
   localparam int unsigned TMR_W = $clog2(LATENCY + 4);

   logic [31:0] r_mem [WORDS];

   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_full;
   logic                  w_empty;
   logic [31:0]           w_head;
   logic [31:0]           w_push_data;
   logic                  w_handshake;
   logic                  w_pop;
   logic                  w_accept_gate;
   logic [TMR_W-1:0]      w_target;
   logic [TMR_W-1:0]      r_timer;
   logic                  w_unused_ok;

   assign w_idx       = sram_addr[ADDR_WIDTH+1:2];
   assign w_unused_ok = ^{sram_size, sram_addr[31:ADDR_WIDTH+2], sram_addr[1:0]};

`ifdef RANDOM_DELAY_EN
   logic [7:0] r_lfsr;
   logic [1:0] r_extra;

   assign w_accept_gate = ~r_lfsr[0];
   assign w_target      = TMR_W'(LATENCY - 1) + TMR_W'(r_extra);

   // Extra wait is latched whenever the timer restarts, i.e. as a new head arrives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lfsr  <= LFSR_SEED;
         r_extra <= '0;
      end else begin
         r_lfsr <= lfsr_next(r_lfsr);
         if (w_pop || w_empty) r_extra <= r_lfsr[2:1];
      end
   end
`else
   assign w_accept_gate = 1'b1;
   assign w_target      = TMR_W'(LATENCY - 1);
`endif

   // Reset gates acceptance so nothing is enqueued while the FIFO is held empty.
   assign sram_addr_ok = sram_req & ~w_full & ~reset & w_accept_gate;
   assign w_handshake  = sram_req & sram_addr_ok;

   // Read data is snapshotted at acceptance so later writes cannot disturb it.
   assign w_push_data = sram_wr ? 32'h0 : r_mem[w_idx];

   assign w_pop        = ~w_empty & (r_timer == w_target);
   assign sram_data_ok = w_pop;
   assign sram_rdata   = w_pop ? w_head : 32'h0;

   always_ff @(posedge clk) begin
      if (w_handshake && sram_wr) r_mem[w_idx] <= sram_merge(r_mem[w_idx], sram_wdata, sram_wstrb);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timer <= '0;
      end else if (w_pop || w_empty) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + TMR_W'(1);
      end
   end

   sram_like_responder_resp_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_resp_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_handshake),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

endmodule
